// File: rtl/uart_tx64.sv
// -----------------------------------------------------------------------------
// uart_tx64
//
// Purpose:
//   Return path for the 64-bit UART receive stage. Accepts one 64-bit word
//   over a valid/ready handshake and serialises it on the UART TX pin as
//   eight 8N1 bytes. The most significant byte goes out first
//   (tx_data[63:56]), and each byte is sent LSB first.
//
// Optional feature (macro UART_TX64_HEADER_EN):
//   When defined, every word is preceded by eight 0xAA sync bytes, so
//   16 bytes go out per word. byte_cnt counts data bytes only.
//   When undefined, only the eight data bytes are sent.
//
// Parameters:
//   CLK_HZ    system clock frequency in Hz
//   BIT_RATE  UART bit rate in bits/s. CLK_HZ/BIT_RATE must be >= 2.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous, active-high reset
//   tx_data   word to send; sampled only on accept
//   tx_valid  a word is available
//   tx_ready  block can accept a word (IDLE only, low during reset)
//   uart_txd  UART TX pin, idles high
//   busy      high from accept until the final stop bit completes
//   byte_cnt  data bytes fully sent in the current word, 0..8
//   done      one-cycle pulse when the final stop bit completes
// -----------------------------------------------------------------------------
module uart_tx64 #(
    parameter int CLK_HZ   = 50000000,
    parameter int BIT_RATE = 9600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        uart_txd,
    output logic        busy,
    output logic [3:0]  byte_cnt,
    output logic        done
);

    localparam int CPB = CLK_HZ / BIT_RATE;
    localparam int CW  = $clog2(CPB);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  baud_q, baud_d;
    logic [2:0]     bit_q, bit_d;
    logic [63:0]    shreg_q, shreg_d;
    logic [3:0]     byte_cnt_q, byte_cnt_d;
    logic           txd_q, txd_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           ready_q, ready_d;
`ifdef UART_TX64_HEADER_EN
    logic           hdr_q, hdr_d;           // currently sending sync header bytes
    logic [2:0]     hdr_cnt_q, hdr_cnt_d;   // header bytes already sent
`endif

    logic           baud_last;
    logic [2:0]     bit_nxt;
    logic [7:0]     cur_byte;

    assign baud_last = (baud_q == CW'(CPB - 1));
    assign bit_nxt   = bit_q + 3'd1;

    // The byte on the wire is always the top byte of the shift register;
    // the register moves left by one byte at the end of each data stop bit.
`ifdef UART_TX64_HEADER_EN
    assign cur_byte = hdr_q ? 8'hAA : shreg_q[63:56];
`else
    assign cur_byte = shreg_q[63:56];
`endif

    // Next-state logic. The line value for the next cycle is computed here
    // and registered, so uart_txd changes exactly on a state/bit boundary.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        byte_cnt_d = byte_cnt_q;
        txd_d      = txd_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ready_d    = ready_q;
`ifdef UART_TX64_HEADER_EN
        hdr_d      = hdr_q;
        hdr_cnt_d  = hdr_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                txd_d   = 1'b1;
                busy_d  = 1'b0;
                ready_d = 1'b1;
                baud_d  = '0;
                bit_d   = 3'd0;
                if (tx_valid && ready_q) begin
                    shreg_d    = tx_data;
                    byte_cnt_d = 4'd0;
                    state_d    = S_START;
                    txd_d      = 1'b0;
                    busy_d     = 1'b1;
                    ready_d    = 1'b0;
`ifdef UART_TX64_HEADER_EN
                    hdr_d      = 1'b1;
                    hdr_cnt_d  = 3'd0;
`endif
                end
            end

            S_START: begin
                if (baud_last) begin
                    state_d = S_DATA;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    txd_d   = cur_byte[0];
                end else begin
                    baud_d  = baud_q + CW'(1);
                end
            end

            S_DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d   = bit_nxt;
                        txd_d   = cur_byte[bit_nxt];
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end

            S_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
`ifdef UART_TX64_HEADER_EN
                    if (hdr_q) begin
                        // Header bytes do not advance byte_cnt or the data.
                        hdr_cnt_d = hdr_cnt_q + 3'd1;
                        if (hdr_cnt_q == 3'd7)
                            hdr_d = 1'b0;
                        state_d = S_START;
                        txd_d   = 1'b0;
                    end else
`endif
                    begin
                        byte_cnt_d = byte_cnt_q + 4'd1;
                        shreg_d    = {shreg_q[55:0], 8'h00};
                        if (byte_cnt_q == 4'd7) begin
                            // Final stop bit: done/ready/idle take effect
                            // together on the first IDLE cycle.
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            ready_d = 1'b1;
                            txd_d   = 1'b1;
                        end else begin
                            state_d = S_START;
                            txd_d   = 1'b0;
                        end
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
                ready_d = 1'b1;
                baud_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_q      <= 3'd0;
            shreg_q    <= 64'd0;
            byte_cnt_q <= 4'd0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b0;
`ifdef UART_TX64_HEADER_EN
            hdr_q      <= 1'b0;
            hdr_cnt_q  <= 3'd0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            byte_cnt_q <= byte_cnt_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
`ifdef UART_TX64_HEADER_EN
            hdr_q      <= hdr_d;
            hdr_cnt_q  <= hdr_cnt_d;
`endif
        end
    end

    assign tx_ready = ready_q;
    assign uart_txd = txd_q;
    assign busy     = busy_q;
    assign byte_cnt = byte_cnt_q;
    assign done     = done_q;

endmodule

// File: tb/tb_uart_tx64.sv
// -----------------------------------------------------------------------------
// tb_uart_tx64
//
// Directed bench for uart_tx64 at CPB = 10. A behavioural UART receiver
// samples the line mid-bit. Expected bytes and timings are derived from the
// words the bench sends.
// -----------------------------------------------------------------------------
module tb_uart_tx64;

    localparam int CLK_HZ   = 1000000;
    localparam int BIT_RATE = 100000;
    localparam int CPB      = 10;
`ifdef UART_TX64_HEADER_EN
    localparam int HB = 8;
`else
    localparam int HB = 0;
`endif
    localparam int NB       = HB + 8;          // bytes on the wire per word
    localparam int WORD_CYC = NB * 10 * CPB;   // cycles per word

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] tx_data = 64'd0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic        uart_txd;
    logic        busy;
    logic [3:0]  byte_cnt;
    logic        done;

    always #5 clk = ~clk;

    uart_tx64 #(
        .CLK_HZ   (CLK_HZ),
        .BIT_RATE (BIT_RATE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .uart_txd (uart_txd),
        .busy     (busy),
        .byte_cnt (byte_cnt),
        .done     (done)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    logic [7:0] rx_bytes [16];
    int         rx_fall0;
    bit         rx_ok;
    logic [3:0] rx_bc_hdr;
    logic [3:0] rx_bc_mid;
    int         last_fall;
    int         last_done;

    function automatic logic [7:0] exp_byte(input logic [63:0] w, input int k);
        if (k < HB) return 8'hAA;
        return w[63 - 8 * (k - HB) -: 8];
    endfunction

    // Receive one 8N1 frame. With in_start set the caller is already at the
    // first sampled cycle of the start bit.
    task automatic recv_byte(input bit in_start, output logic [7:0] b, output bit ok,
                             output int fall, output logic [3:0] bc);
        bit found;
        ok = 1'b1; b = 8'h00; fall = 0; bc = 4'h0; found = in_start;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (uart_txd === 1'b0) found = 1'b1;
        end
        if (!found) begin
            ok = 1'b0;
            return;
        end
        fall = cyc;
        repeat (CPB / 2 - 1) @(negedge clk);
        if (uart_txd !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = uart_txd;
        end
        repeat (CPB) @(negedge clk);
        if (uart_txd !== 1'b1) ok = 1'b0;
        bc = byte_cnt;
    endtask

    task automatic recv_word();
        logic [7:0] b;
        bit         ok;
        int         fall;
        logic [3:0] bc;
        rx_ok = 1'b1; rx_bc_hdr = 4'h0; rx_bc_mid = 4'hF;
        for (int k = 0; k < NB; k++) begin
            recv_byte(k == 0, b, ok, fall, bc);
            rx_bytes[k] = b;
            if (!ok) rx_ok = 1'b0;
            if (k == 0) rx_fall0 = fall;
            if (k == HB - 1) rx_bc_hdr = bc;
            if (k == HB + 2) rx_bc_mid = bc;
        end
    endtask

    // Present a word once tx_ready is seen, hold valid for one edge, and
    // return at the first cycle after the accept edge.
    task automatic start_word(input logic [63:0] w, output bit ok);
        bit rdy;
        rdy = 1'b0;
        for (int i = 0; i < 50 && !rdy; i++) begin
            @(negedge clk);
            if (tx_ready === 1'b1) rdy = 1'b1;
        end
        tx_data  = w;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        ok = rdy && (uart_txd === 1'b0) && (busy === 1'b1) && (tx_ready === 1'b0);
    endtask

    task automatic wait_done(output int dc, output bit ok);
        ok = 1'b0; dc = 0;
        for (int i = 0; i < 120 && !ok; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                dc = cyc;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (uart_txd !== 1'b1) begin failures++; $display("FAIL rst_txd: got %b expected 1", uart_txd); end
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL rst_ready: got %b expected 0", tx_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (byte_cnt !== 4'd0) begin failures++; $display("FAIL rst_byte_cnt: got %0d expected 0", byte_cnt); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done: got %b expected 0", done); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL idle_ready: got %b expected 1", tx_ready); end
        checks++; if (uart_txd !== 1'b1) begin failures++; $display("FAIL idle_txd: got %b expected 1", uart_txd); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL idle_busy_done: got busy=%b done=%b expected 0/0", busy, done); end
        $display("reset: txd=%b ready=%b busy=%b byte_cnt=%0d", uart_txd, tx_ready, busy, byte_cnt);
    endtask

    task automatic test_single_word();
        logic [63:0] w;
        bit ok;
        int dc;
        w = 64'h0123456789ABCDEF;
        start_word(w, ok);
        checks++; if (!ok) begin failures++; $display("FAIL sw_accept: start bit/busy not seen on cycle after accept (txd=%b busy=%b)", uart_txd, busy); end
        recv_word();
        checks++; if (!rx_ok) begin failures++; $display("FAIL sw_frame: got bad start/stop bit expected valid 8N1"); end
        for (int k = 0; k < NB; k++) begin
            checks++;
            if (rx_bytes[k] !== exp_byte(w, k)) begin failures++; $display("FAIL sw_byte%0d: got %02h expected %02h", k, rx_bytes[k], exp_byte(w, k)); end
        end
        checks++; if (rx_bc_mid !== 4'd2) begin failures++; $display("FAIL sw_byte_cnt_mid: got %0d expected 2", rx_bc_mid); end
`ifdef UART_TX64_HEADER_EN
        checks++; if (rx_bc_hdr !== 4'd0) begin failures++; $display("FAIL sw_byte_cnt_hdr: got %0d expected 0", rx_bc_hdr); end
`endif
        wait_done(dc, ok);
        checks++; if (!ok) begin failures++; $display("FAIL sw_done_timeout: got no done expected pulse"); end
        checks++; if (dc - rx_fall0 !== WORD_CYC) begin failures++; $display("FAIL sw_done_time: got %0d expected %0d", dc - rx_fall0, WORD_CYC); end
        checks++; if (busy !== 1'b0 || tx_ready !== 1'b1 || uart_txd !== 1'b1) begin failures++; $display("FAIL sw_done_cycle: got busy=%b ready=%b txd=%b expected 0/1/1", busy, tx_ready, uart_txd); end
        checks++; if (byte_cnt !== 4'd8) begin failures++; $display("FAIL sw_byte_cnt_end: got %0d expected 8", byte_cnt); end
        last_fall = rx_fall0;
        last_done = dc;
        $display("word %016h: sent %02h..%02h done_at=%0d", w, rx_bytes[0], rx_bytes[NB-1], dc - rx_fall0);
    endtask

    // Entered on the done cycle of the previous word.
    task automatic test_back_to_back();
        logic [63:0] w;
        bit ok;
        int dc;
        w = 64'hFFFFFFFF00000000;
        tx_data  = w;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        checks++; if (uart_txd !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL b2b_accept: got txd=%b busy=%b expected 0/1", uart_txd, busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_done_width: got %b expected 0", done); end
        checks++; if (byte_cnt !== 4'd0) begin failures++; $display("FAIL b2b_byte_cnt_clr: got %0d expected 0", byte_cnt); end
        checks++; if (cyc - last_done !== 1) begin failures++; $display("FAIL b2b_gap: got %0d expected 1", cyc - last_done); end
        checks++; if (cyc - last_fall !== WORD_CYC + 1) begin failures++; $display("FAIL b2b_period: got %0d expected %0d", cyc - last_fall, WORD_CYC + 1); end
        recv_word();
        checks++; if (!rx_ok) begin failures++; $display("FAIL b2b_frame: got bad start/stop bit expected valid 8N1"); end
        for (int k = 0; k < NB; k++) begin
            checks++;
            if (rx_bytes[k] !== exp_byte(w, k)) begin failures++; $display("FAIL b2b_byte%0d: got %02h expected %02h", k, rx_bytes[k], exp_byte(w, k)); end
        end
        wait_done(dc, ok);
        checks++; if (!ok || dc - rx_fall0 !== WORD_CYC) begin failures++; $display("FAIL b2b_done_time: got %0d expected %0d", dc - rx_fall0, WORD_CYC); end
        $display("word %016h: sent %02h..%02h done_at=%0d", w, rx_bytes[0], rx_bytes[NB-1], dc - rx_fall0);
    endtask

    task automatic test_busy_ignore();
        logic [63:0] w;
        bit ok;
        bit stop;
        bit ready_hi;
        int dc;
        int dc0;
        w = 64'h5A3C96E1F00F7E81;
        start_word(w, ok);
        checks++; if (!ok) begin failures++; $display("FAIL bi_accept: start bit/busy not seen after accept"); end
        dc0 = done_cnt;
        stop = 1'b0;
        ready_hi = 1'b0;
        tx_valid = 1'b1;
        fork
            begin
                recv_word();
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    @(negedge clk);
                    if (tx_ready !== 1'b0) ready_hi = 1'b1;
                    tx_data = {$urandom, $urandom};
                end
            end
        join
        tx_valid = 1'b0;
        checks++; if (ready_hi) begin failures++; $display("FAIL bi_ready: got tx_ready=1 while busy expected 0"); end
        checks++; if (done_cnt !== dc0) begin failures++; $display("FAIL bi_early_done: got %0d pulses expected 0", done_cnt - dc0); end
        checks++; if (!rx_ok) begin failures++; $display("FAIL bi_frame: got bad start/stop bit expected valid 8N1"); end
        for (int k = 0; k < NB; k++) begin
            checks++;
            if (rx_bytes[k] !== exp_byte(w, k)) begin failures++; $display("FAIL bi_byte%0d: got %02h expected %02h", k, rx_bytes[k], exp_byte(w, k)); end
        end
        wait_done(dc, ok);
        checks++; if (!ok || dc - rx_fall0 !== WORD_CYC) begin failures++; $display("FAIL bi_done_time: got %0d expected %0d", dc - rx_fall0, WORD_CYC); end
        $display("word %016h: sent %02h..%02h with tx_data churn, done_at=%0d", w, rx_bytes[0], rx_bytes[NB-1], dc - rx_fall0);
    endtask

    task automatic test_reset_mid();
        logic [63:0] w;
        logic [63:0] w2;
        logic [7:0]  b;
        bit          ok;
        bit          found;
        bit          line_low;
        int          fall;
        int          dc;
        int          dc0;
        logic [3:0]  bc;
        w = 64'h1122334455667788;
        start_word(w, ok);
        for (int k = 0; k < HB + 3; k++) recv_byte(k == 0, b, ok, fall, bc);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (uart_txd === 1'b0) found = 1'b1;
        end
        // Move to the middle of data bit 4 of data byte 3 (0x44, bit 4 = 0).
        repeat (52) @(negedge clk);
        checks++; if (!found || uart_txd !== 1'b0 || byte_cnt !== 4'd3) begin failures++; $display("FAIL rm_pre: got txd=%b byte_cnt=%0d expected 0/3", uart_txd, byte_cnt); end
        dc0 = done_cnt;
        reset = 1'b1;
        #1;
        checks++; if (uart_txd !== 1'b1) begin failures++; $display("FAIL rm_txd_async: got %b expected 1", uart_txd); end
        checks++; if (byte_cnt !== 4'd0 || busy !== 1'b0) begin failures++; $display("FAIL rm_state: got byte_cnt=%0d busy=%b expected 0/0", byte_cnt, busy); end
        checks++; if (tx_ready !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rm_ready_done: got ready=%b done=%b expected 0/0", tx_ready, done); end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        line_low = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (uart_txd !== 1'b1) line_low = 1'b1;
        end
        checks++; if (line_low) begin failures++; $display("FAIL rm_line_idle: got low line after reset expected high"); end
        checks++; if (done_cnt !== dc0) begin failures++; $display("FAIL rm_no_done: got %0d pulses expected 0", done_cnt - dc0); end
        w2 = 64'hDEADBEEFCAFEF00D;
        start_word(w2, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rm_next_accept: start bit/busy not seen after accept"); end
        recv_word();
        checks++; if (!rx_ok) begin failures++; $display("FAIL rm_next_frame: got bad start/stop bit expected valid 8N1"); end
        for (int k = 0; k < NB; k++) begin
            checks++;
            if (rx_bytes[k] !== exp_byte(w2, k)) begin failures++; $display("FAIL rm_byte%0d: got %02h expected %02h", k, rx_bytes[k], exp_byte(w2, k)); end
        end
        wait_done(dc, ok);
        checks++; if (!ok || dc - rx_fall0 !== WORD_CYC || byte_cnt !== 4'd8) begin failures++; $display("FAIL rm_next_done: got t=%0d byte_cnt=%0d expected %0d/8", dc - rx_fall0, byte_cnt, WORD_CYC); end
        $display("word %016h after mid-word reset: sent %02h..%02h done_at=%0d", w2, rx_bytes[0], rx_bytes[NB-1], dc - rx_fall0);
    endtask

`ifdef UART_TX64_HEADER_EN
    task automatic test_header();
        logic [63:0] w;
        bit ok;
        int dc;
        w = 64'hAAAAAAAAAAAAAAAA;
        start_word(w, ok);
        recv_word();
        checks++; if (!rx_ok) begin failures++; $display("FAIL hdr_frame: got bad start/stop bit expected valid 8N1"); end
        for (int k = 0; k < NB; k++) begin
            checks++;
            if (rx_bytes[k] !== 8'hAA) begin failures++; $display("FAIL hdr_byte%0d: got %02h expected aa", k, rx_bytes[k]); end
        end
        checks++; if (rx_bc_hdr !== 4'd0) begin failures++; $display("FAIL hdr_byte_cnt: got %0d expected 0", rx_bc_hdr); end
        wait_done(dc, ok);
        checks++; if (!ok || dc - rx_fall0 !== 1600) begin failures++; $display("FAIL hdr_done_time: got %0d expected 1600", dc - rx_fall0); end
        $display("word %016h with header: %0d bytes, done_at=%0d", w, NB, dc - rx_fall0);
    endtask
`endif

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
`ifdef UART_TX64_HEADER_EN
        test_header();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
